bcd_share_arbiter: RTL and testbench

- Shares one binary-to-BCD conversion engine (20-bit in, six BCD digits out) among NREQ requesters, e.g. MCP3008 channel scalers and the display path.
- Arbitrates round-robin and issues a start pulse with the winner's operand.
- Waits for the engine's done, then returns the six digits tagged with the requester ID.
- Sits between the ADC post-processing blocks and the shared BCD engine.

---
 rtl/bcd_share_arbiter.sv | 171 +++++++++++++++++
 tb/tb_bcd_share_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_share_arbiter.sv
// ============================================================================
// Module   : bcd_share_arbiter
// Brief    : Round-robin front end that shares one binary-to-BCD engine among
//            NREQ requesters. Optional engine watchdog: BCD_ARB_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_share_arbiter #(
    parameter int NREQ        = 4,
    parameter int DW          = 20,
    parameter int NDIG        = 6,
    parameter int IDW         = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 eng_start,
    output logic [DW-1:0]        eng_data,
    input  logic                 eng_done,
    input  logic [4*NDIG-1:0]    eng_bcd,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [4*NDIG-1:0]    rsp_bcd,
    output logic                 rsp_err,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IDW-1:0] r_rr_ptr;
    logic [IDW-1:0] r_cur_id;
    logic [IDW-1:0] w_win_id;
    logic           w_win_vld;
    logic           w_timeout;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        int idx;
        idx       = 0;
        w_win_vld = 1'b0;
        w_win_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req[idx]) begin
                w_win_vld = 1'b1;
                w_win_id  = IDW'(idx);
            end
        end
    end

`ifdef BCD_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] r_wd_cnt;
    logic          r_rsp_err;

    // Held at zero outside WAIT, so it always starts from zero on WAIT entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt <= '0;
        end else if (r_state != S_WAIT) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_WAIT) && (r_wd_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_err <= 1'b0;
        end else if (r_state == S_WAIT) begin
            if (eng_done) begin
                r_rsp_err <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

    assign rsp_err = r_rsp_err;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYC > 0);
    assign w_timeout      = 1'b0;
    assign rsp_err        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_win_vld) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (eng_done || w_timeout) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pulse outputs default low every cycle; data outputs hold until rewritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= '0;
            eng_start <= 1'b0;
            eng_data  <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_bcd   <= '0;
            r_rr_ptr  <= '0;
            r_cur_id  <= '0;
        end else begin
            gnt       <= '0;
            eng_start <= 1'b0;
            rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_win_vld) begin
                        gnt      <= NREQ'(1) << w_win_id;
                        eng_data <= req_data[int'(w_win_id)*DW +: DW];
                        r_cur_id <= w_win_id;
                    end
                end
                S_ISSUE: begin
                    eng_start <= 1'b1;
                    r_rr_ptr  <= (r_cur_id == IDW'(NREQ - 1)) ? '0 : r_cur_id + 1'b1;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= r_cur_id;
                        rsp_bcd   <= eng_bcd;
                    end else if (w_timeout) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= r_cur_id;
                        rsp_bcd   <= '1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_bcd_share_arbiter.sv
// ============================================================================
// Module   : tb_bcd_share_arbiter
// Brief    : Directed self-checking bench for bcd_share_arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_share_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 20;
    localparam int NDIG = 6;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*DW-1:0]  req_data = '0;
    logic [NREQ-1:0]     gnt;
    logic                eng_start;
    logic [DW-1:0]       eng_data;
    logic                eng_done = 1'b0;
    logic [4*NDIG-1:0]   eng_bcd = '0;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [4*NDIG-1:0]   rsp_bcd;
    logic                rsp_err;
    logic                busy;

    int n_total = 0;
    int n_bad   = 0;

    bcd_share_arbiter #(
        .NREQ(NREQ), .DW(DW), .NDIG(NDIG), .IDW(IDW), .TIMEOUT_CYC(64)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .eng_start(eng_start), .eng_data(eng_data), .eng_done(eng_done),
        .eng_bcd(eng_bcd), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_bcd(rsp_bcd), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [DW-1:0] op);
        req_data[id*DW +: DW] = op;
    endtask

    // Grant, start and result of one transaction; done is driven lat cycles after start.
    task automatic serve(input int id, input logic [DW-1:0] op, input logic [23:0] bcd,
                         input int lat, input bit drop);
        int n;
        n = 0;
        while (gnt == '0 && n < 20) begin
            tick();
            n++;
        end
        check("gnt_latency", n, 1);
        check("gnt", gnt, 32'(1) << id);
        if (drop) req[id] = 1'b0;
        tick();
        check("eng_start", eng_start, 1);
        check("eng_data", eng_data, op);
        repeat (lat) tick();
        eng_done = 1'b1;
        eng_bcd  = bcd;
        tick();
        eng_done = 1'b0;
        eng_bcd  = '0;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, id);
        check("rsp_bcd", rsp_bcd, bcd);
        check("rsp_err", rsp_err, 0);
        tick();
        check("rsp_valid_drop", rsp_valid, 0);
        check("rsp_bcd_hold", rsp_bcd, bcd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit seen;
        int n;

        // Reset state
        tick();
        check("rst_gnt", gnt, 0);
        check("rst_start", eng_start, 0);
        check("rst_eng_data", eng_data, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_bcd", rsp_bcd, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Single request, 45-cycle engine
        set_op(1, 20'd12345);
        req = 4'b0010;
        serve(1, 20'd12345, 24'h012345, 45, 1'b1);
        check("busy_idle", busy, 0);

        // rr_ptr=2: serve 2, then 3 ahead of 0
        set_op(2, 20'd42);
        req = 4'b0100;
        serve(2, 20'd42, 24'h000042, 3, 1'b1);
        set_op(3, 20'd987654);
        set_op(0, 20'd7);
        req = 4'b1001;
        serve(3, 20'd987654, 24'h987654, 5, 1'b1);
        serve(0, 20'd7, 24'h000007, 2, 1'b1);

        // Stray done in IDLE and in ISSUE
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("stray_idle_valid", rsp_valid, 0);
        check("stray_idle_busy", busy, 0);
        set_op(1, 20'd100000);
        req = 4'b0010;
        tick();
        check("stray_gnt", gnt, 4'b0010);
        req = '0;
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check("stray_issue_start", eng_start, 1);
        check("stray_issue_valid", rsp_valid, 0);
        tick();
        check("stray_issue_valid2", rsp_valid, 0);
        check("stray_wait_busy", busy, 1);
        eng_done = 1'b1;
        eng_bcd  = 24'h100000;
        tick();
        eng_done = 1'b0;
        check("stray_rsp_valid", rsp_valid, 1);
        check("stray_rsp_bcd", rsp_bcd, 24'h100000);
        tick();

        // Asynchronous reset in WAIT
        set_op(2, 20'd555);
        req = 4'b0100;
        tick();
        req = '0;
        tick();
        tick();
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_gnt", gnt, 0);
        check("arst_start", eng_start, 0);
        check("arst_eng_data", eng_data, 0);
        check("arst_rsp_bcd", rsp_bcd, 0);
        check("arst_busy", busy, 0);
        tick();
        rst = 1'b0;
        eng_done = 1'b1;
        eng_bcd  = 24'h000555;
        tick();
        eng_done = 1'b0;
        check("arst_late_done", rsp_valid, 0);
        tick();
        check("arst_late_done2", rsp_valid, 0);

        // All four held high: rotation 0,1,2,3,0 from rr_ptr=0
        set_op(0, 20'd11);
        set_op(1, 20'd222);
        set_op(2, 20'd3333);
        set_op(3, 20'd44444);
        req = 4'b1111;
        serve(0, 20'd11, 24'h000011, 4, 1'b0);
        serve(1, 20'd222, 24'h000222, 1, 1'b0);
        serve(2, 20'd3333, 24'h003333, 0, 1'b0);
        serve(3, 20'd44444, 24'h044444, 6, 1'b0);
        serve(0, 20'd11, 24'h000011, 2, 1'b0);
        req = '0;
        tick();

        // Engine never answers
        set_op(2, 20'd77);
        req = 4'b0100;
        tick();
        check("to_gnt", gnt, 4'b0100);
        req = '0;
        tick();
        check("to_start", eng_start, 1);
`ifdef BCD_ARB_TIMEOUT_EN
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
        check("to_latency", n, 64);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_bcd", rsp_bcd, 24'hFFFFFF);
        check("to_rsp_id", rsp_id, 2);
`else
        seen = 1'b0;
        n = 0;
        repeat (100) begin
            tick();
            if (rsp_valid) seen = 1'b1;
            n++;
        end
        check("noto_valid", seen, 0);
        check("noto_busy", busy, 1);
        check("noto_err", rsp_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
